// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse period meter and its helpers.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH     = 30;
  localparam logic [29:0] DEFAULT_MAX_CLKS  = 30'h3FFF_FFFF;
  localparam int unsigned DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/pulse_period_meter_edge_detect.sv
// Rising-edge detector: registers the input once and flags a low-to-high change.
module pulse_period_meter_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  // A level held high produces a single rise in its first cycle.
  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clocks between successive rising edges of pulse_in and reports each
// period on a valid/ready port. Build with PULSE_METER_MINMAX_EN for min/max tracking.
module pulse_period_meter
  import pulse_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_CLKS  = WIDTH'(DEFAULT_MAX_CLKS),
  parameter int unsigned      CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 pulse_in,
  output logic [WIDTH-1:0]     period,
  output logic                 period_valid,
  input  logic                 period_ready,
  output logic                 overrun,
  output logic                 timeout,
  input  logic                 clear_flags,
  output logic [CNT_WIDTH-1:0] period_count,
`ifdef PULSE_METER_MINMAX_EN
  output logic [WIDTH-1:0]     min_period,
  output logic [WIDTH-1:0]     max_period,
`endif
  output state_t               state
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     period_q;
  logic                 valid_q;
  logic                 overrun_q;
  logic                 timeout_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 rise;
  logic                 capture;
  logic                 timeout_hit;
  logic                 accept;

  pulse_period_meter_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (pulse_in),
    .rise_o (rise)
  );

  // Result port: the result moves when period_valid & period_ready are both high
  // at a clock edge; period holds still while valid unless a new capture replaces it.
  assign accept = valid_q & period_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_FIRST;
          cnt_d   = '0;
        end
        WAIT_FIRST: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = WIDTH'(1);
          end
        end
        MEASURE: begin
          // An edge landing exactly at MAX_CLKS is still a valid capture.
          if (rise) begin
            capture = 1'b1;
            cnt_d   = WIDTH'(1);
          end else if (cnt_q == MAX_CLKS) begin
            timeout_hit = 1'b1;
            cnt_d       = '0;
            state_d     = WAIT_FIRST;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (capture) begin
        period_q <= cnt_q;
        valid_q  <= 1'b1;
        count_q  <= count_q + CNT_WIDTH'(1);
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      // Set conditions take priority over clear_flags.
      if (capture && valid_q && !period_ready) overrun_q <= 1'b1;
      else if (clear_flags)                    overrun_q <= 1'b0;

      if (timeout_hit)      timeout_q <= 1'b1;
      else if (clear_flags) timeout_q <= 1'b0;
    end
  end

`ifdef PULSE_METER_MINMAX_EN
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else if (capture) begin
      // A capture alongside clear_flags restarts tracking from this period.
      if (clear_flags || cnt_q < min_q) min_q <= cnt_q;
      if (clear_flags || cnt_q > max_q) max_q <= cnt_q;
    end else if (clear_flags) begin
      min_q <= '1;
      max_q <= '0;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`endif

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;
  assign period_count = count_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: table vectors, directed corner
// sequences and random traffic against a timestamp-based reference model.
module tb_pulse_period_meter;
  import pulse_pkg::*;

  localparam int unsigned W    = 30;
  localparam int unsigned CW   = 16;
  localparam int          MAXC = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset        = 1'b1;
  logic           enable       = 1'b0;
  logic           pulse_in     = 1'b0;
  logic           period_ready = 1'b0;
  logic           clear_flags  = 1'b0;
  logic [W-1:0]   period;
  logic           period_valid;
  logic           overrun;
  logic           timeout;
  logic [CW-1:0]  period_count;
  state_t         state;
`ifdef PULSE_METER_MINMAX_EN
  logic [W-1:0]   min_period;
  logic [W-1:0]   max_period;
`endif

  pulse_period_meter #(
    .WIDTH     (W),
    .MAX_CLKS  (30'd50),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overrun      (overrun),
    .timeout      (timeout),
    .clear_flags  (clear_flags),
    .period_count (period_count),
`ifdef PULSE_METER_MINMAX_EN
    .min_period   (min_period),
    .max_period   (max_period),
`endif
    .state        (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks absolute cycle numbers: a period is the distance between two
  // edge timestamps seen while the meter is active and armed.
  int           t = 0;
  int           m_t0 = 0;
  bit           m_active = 1'b0;
  bit           m_armed = 1'b0;
  bit           m_prev = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_period = '0;
  bit           m_ovr = 1'b0;
  bit           m_to = 1'b0;
  int           m_count = 0;
  logic [W-1:0] m_min = '1;
  logic [W-1:0] m_max = '0;

  task automatic model_step();
    bit rise_m, cap, to_set;
    int el;
    logic [W-1:0] val;
    t++;
    if (reset) begin
      m_active = 0; m_armed = 0; m_prev = 0; exp_q.delete();
      m_period = '0; m_ovr = 0; m_to = 0; m_count = 0;
      m_min = '1; m_max = '0;
      return;
    end
    rise_m = pulse_in && !m_prev;
    cap = 0; to_set = 0; val = '0;
    if (m_active && enable) begin
      if (m_armed) begin
        el = t - m_t0;
        if (rise_m) begin
          cap = 1; val = W'(el); m_t0 = t;
        end else if (el >= MAXC) begin
          to_set = 1; m_armed = 0;
        end
      end else if (rise_m) begin
        m_armed = 1; m_t0 = t;
      end
    end else begin
      m_armed = 0;
    end
    m_active = enable;

    if (cap) begin
      if (exp_q.size() != 0 && !period_ready) m_ovr = 1;
      else if (clear_flags) m_ovr = 0;
      exp_q.delete();
      exp_q.push_back(val);
      m_period = val;
      m_count = (m_count + 1) % (1 << CW);
      if (clear_flags) begin
        m_min = val; m_max = val;
      end else begin
        if (val < m_min) m_min = val;
        if (val > m_max) m_max = val;
      end
    end else begin
      if (exp_q.size() != 0 && period_ready) void'(exp_q.pop_front());
      if (clear_flags) begin
        m_ovr = 0; m_min = '1; m_max = '0;
      end
    end
    if (to_set) m_to = 1;
    else if (clear_flags) m_to = 0;
    m_prev = pulse_in;
  endtask

  task automatic check_all();
    state_t es;
    es = !m_active ? IDLE : (m_armed ? MEASURE : WAIT_FIRST);
    chk("period", 32'(period), 32'(m_period));
    chk("period_valid", 32'(period_valid), 32'(exp_q.size() != 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("period_count", 32'(period_count), 32'(m_count));
    chk("state", 32'(state), 32'(es));
`ifdef PULSE_METER_MINMAX_EN
    chk("min_period", 32'(min_period), 32'(m_min));
    chk("max_period", 32'(max_period), 32'(m_max));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit en, input bit p, input bit rdy, input bit clr);
    enable = en; pulse_in = p; period_ready = rdy; clear_flags = clr;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    reset = 1'b0;
  endtask

  task automatic silent(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, rdy, 1'b0);
      cycle();
    end
  endtask

  task automatic edge_once(input bit rdy);
    drive(1'b1, 1'b1, rdy, 1'b0);
    cycle();
  endtask

  task automatic pulse_train(input int per, input int high, input int ncyc, input bit rdy);
    for (int k = 0; k < ncyc; k++) begin
      drive(1'b1, (k % per) < high, rdy, 1'b0);
      cycle();
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0]    in;  // {enable, pulse_in, period_ready, clear_flags}
    state_t        st;
    logic          vld;
    logic [W-1:0]  per;
    logic          ovr;
    logic [CW-1:0] cnt;
  } row_t;

  function automatic row_t mk(input logic [3:0] in, input state_t st, input logic vld,
                              input int per, input logic ovr, input int cnt);
    row_t r;
    r.in = in; r.st = st; r.vld = vld; r.per = W'(per); r.ovr = ovr; r.cnt = CW'(cnt);
    return r;
  endfunction

  row_t tbl[18];

  initial begin
    tbl[0]  = mk(4'b1000, WAIT_FIRST, 1'b0, 0, 1'b0, 0);
    tbl[1]  = mk(4'b1100, MEASURE,    1'b0, 0, 1'b0, 0);
    tbl[2]  = mk(4'b1100, MEASURE,    1'b0, 0, 1'b0, 0);
    tbl[3]  = mk(4'b1000, MEASURE,    1'b0, 0, 1'b0, 0);
    tbl[4]  = mk(4'b1100, MEASURE,    1'b1, 3, 1'b0, 1);
    tbl[5]  = mk(4'b1000, MEASURE,    1'b1, 3, 1'b0, 1);
    tbl[6]  = mk(4'b1000, MEASURE,    1'b1, 3, 1'b0, 1);
    tbl[7]  = mk(4'b1100, MEASURE,    1'b1, 3, 1'b1, 2);
    tbl[8]  = mk(4'b1010, MEASURE,    1'b0, 3, 1'b1, 2);
    tbl[9]  = mk(4'b1001, MEASURE,    1'b0, 3, 1'b0, 2);
    tbl[10] = mk(4'b1000, MEASURE,    1'b0, 3, 1'b0, 2);
    tbl[11] = mk(4'b1110, MEASURE,    1'b1, 4, 1'b0, 3);
    tbl[12] = mk(4'b1010, MEASURE,    1'b0, 4, 1'b0, 3);
    tbl[13] = mk(4'b1100, MEASURE,    1'b1, 2, 1'b0, 4);
    tbl[14] = mk(4'b1000, MEASURE,    1'b1, 2, 1'b0, 4);
    tbl[15] = mk(4'b1110, MEASURE,    1'b1, 2, 1'b0, 5);
    tbl[16] = mk(4'b1010, MEASURE,    1'b0, 2, 1'b0, 5);
    tbl[17] = mk(4'b0000, IDLE,       1'b0, 2, 1'b0, 5);

    #1;
    do_reset();
    chk("reset_period", 32'(period), 32'd0);
    chk("reset_valid", 32'(period_valid), 32'd0);
    chk("reset_count", 32'(period_count), 32'd0);
    chk("reset_state", 32'(state), 32'(IDLE));

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      cycle();
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_valid", i), 32'(period_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_period", i), 32'(period), 32'(tbl[i].per));
      chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].ovr));
      chk($sformatf("tbl%0d_count", i), 32'(period_count), 32'(tbl[i].cnt));
    end

    // Loopback of a generator with clks_per_pulse=9: edges every 10 clocks.
    do_reset();
    silent(1, 1'b1);
    pulse_train(10, 1, 60, 1'b1);
    chk("loop_period", 32'(period), 32'd10);
    chk("loop_count", 32'(period_count), 32'd5);
    chk("loop_overrun", 32'(overrun), 32'd0);

    // Long pulses: 5 high out of every 20 count once each.
    do_reset();
    silent(1, 1'b1);
    pulse_train(20, 5, 80, 1'b1);
    chk("long_period", 32'(period), 32'd20);
    chk("long_count", 32'(period_count), 32'd3);

    // Unconsumed results overwrite and raise overrun.
    do_reset();
    silent(1, 1'b0);
    pulse_train(10, 1, 31, 1'b0);
    chk("ovr_valid", 32'(period_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_period", 32'(period), 32'd10);
    chk("ovr_count", 32'(period_count), 32'd3);
    silent(1, 1'b1);
    chk("ovr_drain_valid", 32'(period_valid), 32'd0);

    // Timeout after MAX_CLKS of silence, then recovery and a capture exactly at MAX_CLKS.
    do_reset();
    silent(1, 1'b1);
    edge_once(1'b1);
    silent(49, 1'b1);
    chk("to_before", 32'(timeout), 32'd0);
    silent(1, 1'b1);
    chk("to_set", 32'(timeout), 32'd1);
    chk("to_state", 32'(state), 32'(WAIT_FIRST));
    edge_once(1'b1);
    silent(11, 1'b1);
    edge_once(1'b1);
    chk("to_recover_period", 32'(period), 32'd12);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("to_cleared", 32'(timeout), 32'd0);
    silent(48, 1'b1);
    edge_once(1'b1);
    chk("max_period_cap", 32'(period), 32'd50);
    chk("max_no_timeout", 32'(timeout), 32'd0);
    chk("max_count", 32'(period_count), 32'd2);

    // Enable dropped mid-measure keeps the pending result; re-enable needs two edges.
    do_reset();
    silent(1, 1'b0);
    edge_once(1'b0);
    silent(5, 1'b0);
    edge_once(1'b0);
    silent(3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("dis_state", 32'(state), 32'(IDLE));
    chk("dis_valid", 32'(period_valid), 32'd1);
    chk("dis_period", 32'(period), 32'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    silent(1, 1'b0);
    edge_once(1'b0);
    chk("reen_count", 32'(period_count), 32'd1);
    silent(4, 1'b0);
    edge_once(1'b0);
    chk("reen_period", 32'(period), 32'd5);
    silent(3, 1'b0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    reset = 1'b0;
    chk("rst_mid_valid", 32'(period_valid), 32'd0);
    chk("rst_mid_period", 32'(period), 32'd0);
    chk("rst_mid_overrun", 32'(overrun), 32'd0);
    chk("rst_mid_state", 32'(state), 32'(IDLE));

`ifdef PULSE_METER_MINMAX_EN
    do_reset();
    chk("mm_reset_min", 32'(min_period), 32'h3FFF_FFFF);
    silent(1, 1'b1);
    edge_once(1'b1);
    silent(7, 1'b1);
    edge_once(1'b1);
    silent(14, 1'b1);
    edge_once(1'b1);
    silent(10, 1'b1);
    edge_once(1'b1);
    chk("mm_min", 32'(min_period), 32'd8);
    chk("mm_max", 32'(max_period), 32'd15);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("mm_clr_min", 32'(min_period), 32'h3FFF_FFFF);
    chk("mm_clr_max", 32'(max_period), 32'd0);
`endif

    // Random traffic: bursts of pulses with random gaps, some long enough to time out.
    do_reset();
    begin
      int gap = 1;
      int high = 1;
      int k = 0;
      for (int i = 0; i < 4000; i++) begin
        if (k >= gap) begin
          gap  = $urandom_range(1, 70);
          high = $urandom_range(1, (gap > 8) ? 8 : gap);
          k    = 0;
        end
        reset = ($urandom_range(0, 999) < 3);
        drive($urandom_range(0, 99) < 97, k < high,
              $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
        cycle();
        k++;
      end
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receive-side counterpart of the pulse generator: measures the clock count between successive rising edges on a pulse input.
- Reports each period through a valid/ready result port.
- Sits beside the generator for self-check (loopback) and measures externally supplied tick or strobe inputs for the cylon timing logic.
- Detects overrun (result not consumed in time) and timeout (pulse stopped).

Parameters:
- WIDTH, 30, width of period counter and result; matches the generator's clks_per_pulse width.
- MAX_CLKS, 30'h3FFF_FFFF, timeout threshold in clocks; legal range 2..2^WIDTH-1.
- CNT_WIDTH, 16, width of the captured-period counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  measurement enable
- pulse_in  input  1  pulse to measure; synchronous to clk; any high width
- period  output  WIDTH  last measured period in clocks
- period_valid  output  1  period holds an unconsumed result
- period_ready  input  1  consumer accepts period when high with period_valid
- overrun  output  1  sticky: a result was overwritten before acceptance
- timeout  output  1  sticky: no edge within MAX_CLKS clocks
- clear_flags  input  1  clears overrun and timeout (and min/max when compiled in)
- period_count  output  CNT_WIDTH  number of periods captured; wraps

Behaviour:
- Reset values: period=0, period_valid=0, overrun=0, timeout=0, period_count=0, state=IDLE, cnt=0, pulse_q=0.
- Reset mid-operation: everything returns to the reset values and any pending result is discarded.
- Edge detect: pulse_q registers pulse_in each cycle, and edge = pulse_in & ~pulse_q. A pulse held high yields one edge.
- States:
  - IDLE: entered when enable=0. cnt=0 and edges are ignored.
  - WAIT_FIRST: entered when enable=1. On an edge, cnt<=1 and the block moves to MEASURE. No capture.
  - MEASURE: cnt increments by 1 per cycle.
    - On an edge: period<=cnt, period_valid<=1, period_count+=1, cnt<=1, and the block stays in MEASURE.
    - If cnt==MAX_CLKS and there is no edge: timeout<=1, cnt<=0, the block moves to WAIT_FIRST and nothing is captured.
    - An edge at cnt==MAX_CLKS is a valid capture of MAX_CLKS.
- Period definition: edges in cycles t0 and t1 give period = t1-t0.
  - Latency: period_valid rises in cycle t1+1.
  - A generator programmed with clks_per_pulse=N gives period N+1.
- enable falling: the block goes to IDLE next cycle. A pending result and its period_valid are kept until accepted.
- Handshake:
  - A result is accepted in any cycle with period_valid & period_ready; period_valid then drops next cycle unless a new capture occurs in the same cycle.
  - Capture with period_valid=1 and period_ready=0: period is overwritten with the new value, period_valid stays 1, and overrun<=1.
  - Capture in the same cycle as an acceptance: the new value is loaded, period_valid stays 1, and no overrun.
  - period is stable while period_valid=1 and no capture occurs.
- Sticky flags: clear_flags clears them next cycle. A set condition in the same cycle as clear_flags wins (flag reads 1).
- Arithmetic: cnt never exceeds MAX_CLKS. period_count wraps modulo 2^CNT_WIDTH.

Optional Feature:
- Macro: PULSE_METER_MINMAX_EN.
- Defined: adds outputs min_period and max_period (WIDTH each).
  - Reset values: min_period=all-ones, max_period=0.
  - Updated on every capture.
  - clear_flags restores the reset values; a capture in the same cycle as clear_flags wins over the clear.
- Undefined: these ports and registers do not exist and the behaviour above is unchanged.

Decomposition:
- Shared package pulse_pkg: state enum (IDLE, WAIT_FIRST, MEASURE), default WIDTH=30, default MAX_CLKS.
- One sub-module is natural: edge_detect (pulse_q register plus the rise output), reusable for button and strobe inputs.

Test Plan:
- Generator clks_per_pulse=9 looped to pulse_in, period_ready=1 -> first capture after the second edge, period=10 every capture, overrun=0, period_count increments by 1 per edge.
- pulse_in high for 5 cycles every 20 cycles -> period=20; the long pulse counts once.
- period_ready=0, three periods of 10 -> period_valid=1, overrun=1, period=10, period_count=3. Then ready for one cycle -> period_valid=0 next cycle.
- MAX_CLKS=50, one edge and then silence -> timeout=1 in the cycle after cnt reaches 50, state=WAIT_FIRST. Next two edges 12 apart -> period=12. Edge exactly at cnt=50 -> period=50, timeout stays 0.
- enable deasserted mid-MEASURE and reset asserted mid-MEASURE -> IDLE with the pending result held (enable case) or all outputs at reset values (reset case). Re-enable -> the first edge gives no capture.
- With PULSE_METER_MINMAX_EN, periods 8, 15, 11 -> min_period=8, max_period=15. clear_flags -> all-ones and 0.
